// File: rtl/scale_pkg.sv
// Shared types and constants for the horizontal scaler blocks.
// FSM states, step limits and coefficient ceiling.
package scale_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_e;

   localparam logic [15:0] STEP_ONE = 16'h0100;
   localparam logic [15:0] STEP_MIN = 16'h0001;
   localparam logic [7:0]  COFF_MAX = 8'd255;

   // Only unity or upscale ratios are supported.
   function automatic logic [15:0] clamp_step(input logic [15:0] s);
      return (s == 16'h0000) ? STEP_MIN :
             (s > STEP_ONE)  ? STEP_ONE : s;
   endfunction

endpackage

// File: rtl/hscale_coef_gen_if.sv
// Source pixel valid/ready stream into the coefficient generator.
// master = pixel producer, slave = scaler.
interface hscale_coef_gen_if #(
   parameter int PIX_W = 24
);
   logic [PIX_W-1:0] in_pix;
   logic             in_valid;
   logic             in_ready;

   modport master (
      output in_pix,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_pix,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/hscale_coef_gen_phase.sv
// hscale_phase_acc: clamped 8.8 step, phase accumulator and
// integer-advance flag for the next output.
module hscale_phase_acc
   import scale_pkg::*;
#(
   parameter int W_MAX = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] step_in,
   input  logic        advance,
   output logic [7:0]  frac,
   output logic        adv
);
   localparam int AW = W_MAX + 8;

   logic [AW-1:0] acc_q, acc_d;
   logic [8:0]    step_q, step_d;

   always_comb begin
      acc_d  = acc_q;
      step_d = step_q;
      if (load) begin
         step_d = 9'(clamp_step(step_in));
         acc_d  = '0;
      end else if (advance) begin
         acc_d = acc_q + AW'(step_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         step_q <= '0;
      end else begin
         acc_q  <= acc_d;
         step_q <= step_d;
      end
   end

   // Step never exceeds one pixel, so a fraction carry is the advance.
   assign adv  = ({1'b0, acc_q[7:0]} + step_q) > 9'd255;
   assign frac = acc_q[7:0];

endmodule

// File: rtl/hscale_coef_gen.sv
// Horizontal upscaler: neighbour pixels and linear weights per output.
// Define HSCALE_BYPASS_EN to add the pass-through bypass port.
module hscale_coef_gen
   import scale_pkg::*;
#(
   parameter int W_MAX = 12,
   parameter int PIX_W = 24
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             line_start,
   input  logic [W_MAX-1:0] src_width,
   input  logic [W_MAX-1:0] dst_width,
   input  logic [15:0]      step,
   input  logic [7:0]       v_a_coff,
   input  logic [7:0]       v_b_coff,
`ifdef HSCALE_BYPASS_EN
   input  logic             bypass,
`endif
   hscale_coef_gen_if.slave pix,
   output logic [PIX_W-1:0] a,
   output logic [PIX_W-1:0] b,
   output logic [7:0]       a_coff,
   output logic [7:0]       b_coff,
   output logic [7:0]       a_coff_next,
   output logic [7:0]       b_coff_next,
   output logic             data_en_out,
   output logic             scale_en_out
);
   state_e state_q, state_d;
   logic [W_MAX-1:0] src_q, src_d, dst_q, dst_d;
   logic [W_MAX-1:0] cnt_q, cnt_d, out_q, out_d;
   logic [PIX_W-1:0] p0_q, p0_d, p1_q, p1_d;
   logic [PIX_W-1:0] a_q, a_d, b_q, b_d;
   logic [7:0] ac_q, ac_d, bc_q, bc_d;
   logic [7:0] an_q, an_d, bn_q, bn_d;
   logic sen_q, sen_d, den_q, den_d;
   logic [7:0] frac;
   logic adv, go, need, last, empty, rdy, xfer;
`ifdef HSCALE_BYPASS_EN
   logic byp_q, byp_d;
`endif

   hscale_phase_acc #(.W_MAX(W_MAX)) u_acc (
      .clk    (sys_clk),
      .rst    (rst),
      .load   (line_start),
      .step_in(step),
      .advance(go),
      .frac   (frac),
      .adv    (adv)
   );

   assign last = (out_q == dst_q - W_MAX'(1));
   assign need = adv && (cnt_q < src_q) && !last;
`ifdef HSCALE_BYPASS_EN
   assign empty = (src_width == '0) ||
                  (!bypass && dst_width == '0);
   assign rdy = (state_q == PRIME) ||
                (state_q == RUN &&
                 (byp_q ? (cnt_q < src_q) : need));
`else
   assign empty = (src_width == '0) || (dst_width == '0);
   assign rdy = (state_q == PRIME) ||
                (state_q == RUN && need);
`endif
   assign xfer = pix.in_valid && rdy;
   assign pix.in_ready = rdy;

   always_comb begin
      state_d = state_q;
      src_d = src_q;
      dst_d = dst_q;
      cnt_d = cnt_q;
      out_d = out_q;
      p0_d = p0_q;
      p1_d = p1_q;
      a_d = a_q;
      b_d = b_q;
      ac_d = ac_q;
      bc_d = bc_q;
      an_d = an_q;
      bn_d = bn_q;
      sen_d = 1'b0;
      den_d = 1'b0;
      go = 1'b0;
`ifdef HSCALE_BYPASS_EN
      byp_d = byp_q;
`endif
      unique case (state_q)
         IDLE: state_d = IDLE;
         PRIME: begin
            if (xfer) begin
               cnt_d = cnt_q + W_MAX'(1);
               p1_d = pix.in_pix;
               // First pixel also fills p1 so a 1-pixel line replicates.
               if (cnt_q == '0) begin
                  p0_d = pix.in_pix;
                  if (src_q == W_MAX'(1)) state_d = RUN;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
`ifdef HSCALE_BYPASS_EN
            if (byp_q) begin
               go = xfer;
               if (go) begin
                  a_d = pix.in_pix;
                  b_d = pix.in_pix;
                  ac_d = COFF_MAX;
                  bc_d = '0;
                  cnt_d = cnt_q + W_MAX'(1);
               end
            end else
`endif
            begin
               go = !need || pix.in_valid;
               if (go) begin
                  a_d = p0_q;
                  b_d = p1_q;
                  ac_d = COFF_MAX - frac;
                  bc_d = frac;
                  // Past the right edge p1 stays put: edge replicate.
                  if (adv) p0_d = p1_q;
                  if (need) begin
                     p1_d = pix.in_pix;
                     cnt_d = cnt_q + W_MAX'(1);
                  end
               end
            end
            den_d = den_q || go;
            if (go) begin
               sen_d = 1'b1;
               out_d = out_q + W_MAX'(1);
               if (last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (line_start) begin
         state_d = empty ? IDLE : PRIME;
         src_d = src_width;
         dst_d = dst_width;
         cnt_d = '0;
         out_d = '0;
         an_d = v_a_coff;
         bn_d = v_b_coff;
         sen_d = 1'b0;
         den_d = 1'b0;
`ifdef HSCALE_BYPASS_EN
         byp_d = bypass;
         if (bypass) begin
            dst_d = src_width;
            if (!empty) state_d = RUN;
         end
`endif
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q <= '0;
         dst_q <= '0;
         cnt_q <= '0;
         out_q <= '0;
         p0_q <= '0;
         p1_q <= '0;
         a_q <= '0;
         b_q <= '0;
         ac_q <= '0;
         bc_q <= '0;
         an_q <= '0;
         bn_q <= '0;
         sen_q <= 1'b0;
         den_q <= 1'b0;
`ifdef HSCALE_BYPASS_EN
         byp_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         src_q <= src_d;
         dst_q <= dst_d;
         cnt_q <= cnt_d;
         out_q <= out_d;
         p0_q <= p0_d;
         p1_q <= p1_d;
         a_q <= a_d;
         b_q <= b_d;
         ac_q <= ac_d;
         bc_q <= bc_d;
         an_q <= an_d;
         bn_q <= bn_d;
         sen_q <= sen_d;
         den_q <= den_d;
`ifdef HSCALE_BYPASS_EN
         byp_q <= byp_d;
`endif
      end
   end

   assign a = a_q;
   assign b = b_q;
   assign a_coff = ac_q;
   assign b_coff = bc_q;
   assign a_coff_next = an_q;
   assign b_coff_next = bn_q;
   assign data_en_out = den_q;
   assign scale_en_out = sen_q;

endmodule

// File: tb/tb_hscale_coef_gen.sv
// Directed bench for hscale_coef_gen with an output scoreboard.
// Expected outputs come from the k*step interpolation formula.
module tb_hscale_coef_gen;

   logic        sys_clk;
   logic        rst;
   logic        line_start;
   logic [11:0] src_width;
   logic [11:0] dst_width;
   logic [15:0] step;
   logic [7:0]  v_a_coff;
   logic [7:0]  v_b_coff;
`ifdef HSCALE_BYPASS_EN
   logic        bypass;
`endif
   logic [23:0] a, b;
   logic [7:0]  a_coff, b_coff;
   logic [7:0]  a_coff_next, b_coff_next;
   logic        data_en_out, scale_en_out;

   hscale_coef_gen_if #(.PIX_W(24)) pix_if ();

   hscale_coef_gen #(.W_MAX(12), .PIX_W(24)) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .line_start  (line_start),
      .src_width   (src_width),
      .dst_width   (dst_width),
      .step        (step),
      .v_a_coff    (v_a_coff),
      .v_b_coff    (v_b_coff),
`ifdef HSCALE_BYPASS_EN
      .bypass      (bypass),
`endif
      .pix         (pix_if),
      .a           (a),
      .b           (b),
      .a_coff      (a_coff),
      .b_coff      (b_coff),
      .a_coff_next (a_coff_next),
      .b_coff_next (b_coff_next),
      .data_en_out (data_en_out),
      .scale_en_out(scale_en_out)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];
   logic [23:0] pix_tab [16];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input int src,
      input logic [15:0] stp, input int k, input bit byp);
      int st, accv, i, f, ib;
      if (byp) return {pix_tab[k], pix_tab[k], 8'hFF, 8'h00};
      st = (stp == 16'h0) ? 1 : (stp > 16'h0100) ? 256 : int'(stp);
      accv = k * st;
      i = accv >> 8;
      f = accv & 255;
      ib = (i + 1 > src - 1) ? src - 1 : i + 1;
      if (i > src - 1) i = src - 1;
      return {pix_tab[i], pix_tab[ib], 8'(255 - f), 8'(f)};
   endfunction

   always @(negedge sys_clk) begin
      logic [63:0] e;
      if (scale_en_out === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_empty got=output exp=none");
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_out", {a, b, a_coff, b_coff}, e);
         end
      end
   end

   task automatic run_line(input int src, input int dst,
      input logic [15:0] stp, input bit byp, input int gap_at,
      input int gap_len, input int abort_after,
      input int exp_acc, input int exp_den);
      int dst_eff, n_exp, idx, outs, den_cnt, gap_cnt;
      bit hs, done;
      logic [7:0] va;
      dst_eff = byp ? src : dst;
      if (src == 0) dst_eff = 0;
      n_exp = (abort_after > 0) ? abort_after : dst_eff;
      for (int k = 0; k < n_exp; k++)
         exp_q.push_back(model(src, stp, k, byp));
      va = stp[7:0] ^ 8'h3C;
      src_width = 12'(src);
      dst_width = 12'(dst);
      step = stp;
      v_a_coff = va;
      v_b_coff = ~va;
`ifdef HSCALE_BYPASS_EN
      bypass = byp;
`endif
      pix_if.in_valid = 1'b0;
      line_start = 1'b1;
      @(negedge sys_clk);
      line_start = 1'b0;
      chk("den_drop", data_en_out, 0);
      chk("coff_next", {a_coff_next, b_coff_next}, {va, ~va});
      idx = 0; outs = 0; den_cnt = 0; gap_cnt = 0;
      hs = 0; done = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (hs) idx++;
         if (scale_en_out) outs++;
         if (data_en_out) den_cnt++;
         if (abort_after > 0 && outs == abort_after) begin
            done = 1;
            break;
         end
         if (outs == dst_eff && !data_en_out && cyc >= 4) begin
            done = 1;
            break;
         end
         if (idx == gap_at && gap_cnt < gap_len) begin
            pix_if.in_valid = 1'b0;
            gap_cnt++;
         end else begin
            pix_if.in_valid = 1'b1;
         end
         pix_if.in_pix = (idx < src) ? pix_tab[idx] : 24'hBADBAD;
         hs = pix_if.in_valid && pix_if.in_ready;
         @(negedge sys_clk);
      end
      chk("line_done", done, 1);
      if (abort_after == 0) begin
         chk("outputs", outs, dst_eff);
         chk("accepted", idx, exp_acc);
         chk("den_cycles", den_cnt, exp_den);
      end
   endtask

   initial begin
      rst = 1'b1;
      line_start = 1'b0;
      src_width = '0;
      dst_width = '0;
      step = '0;
      v_a_coff = '0;
      v_b_coff = '0;
`ifdef HSCALE_BYPASS_EN
      bypass = 1'b0;
`endif
      pix_if.in_valid = 1'b0;
      pix_if.in_pix = '0;
      repeat (3) @(negedge sys_clk);
      chk("rst_a", a, 0);
      chk("rst_b", b, 0);
      chk("rst_coff", {a_coff, b_coff}, 0);
      chk("rst_next", {a_coff_next, b_coff_next}, 0);
      chk("rst_en", {data_en_out, scale_en_out}, 0);
      chk("rst_rdy", pix_if.in_ready, 0);
      rst = 1'b0;
      @(negedge sys_clk);

      for (int j = 0; j < 16; j++) pix_tab[j] = 24'((j + 1) * 16);
      run_line(4, 8, 16'h0080, 0, -1, 0, 0, 4, 8);

      for (int j = 0; j < 16; j++) pix_tab[j] = 24'h010203 * 24'(j + 1);
      run_line(5, 5, 16'h0100, 0, -1, 0, 0, 5, 5);
      run_line(4, 4, 16'h0300, 0, -1, 0, 0, 4, 4);
      run_line(2, 4, 16'h0000, 0, -1, 0, 0, 2, 4);
      run_line(6, 6, 16'h0100, 0, 3, 3, 0, 6, 9);
      run_line(1, 3, 16'h0080, 0, -1, 0, 0, 1, 3);
      run_line(4, 0, 16'h0080, 0, -1, 0, 0, 0, 0);
      run_line(0, 3, 16'h0080, 0, -1, 0, 0, 0, 0);

      for (int j = 0; j < 16; j++) pix_tab[j] = 24'h100000 + 24'(j * 17);
      run_line(4, 8, 16'h0080, 0, -1, 0, 3, -1, -1);
      for (int j = 0; j < 16; j++) pix_tab[j] = 24'h00A000 + 24'(j * 5);
      run_line(3, 3, 16'h0100, 0, -1, 0, 0, 3, 3);

      run_line(4, 8, 16'h0080, 0, -1, 0, 3, -1, -1);
      pix_if.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge sys_clk);
      chk("mid_rst_ab", {a, b}, 0);
      chk("mid_rst_coff", {a_coff, b_coff, a_coff_next, b_coff_next}, 0);
      chk("mid_rst_en", {data_en_out, scale_en_out, pix_if.in_ready}, 0);
      rst = 1'b0;
      @(negedge sys_clk);

      rst = 1'b1;
      line_start = 1'b1;
      src_width = 12'd4;
      dst_width = 12'd4;
      step = 16'h0100;
      @(negedge sys_clk);
      rst = 1'b0;
      line_start = 1'b0;
      pix_if.in_valid = 1'b1;
      repeat (2) @(negedge sys_clk);
      chk("rst_prio_rdy", pix_if.in_ready, 0);
      chk("rst_prio_en", {data_en_out, scale_en_out}, 0);
      pix_if.in_valid = 1'b0;
      @(negedge sys_clk);

`ifdef HSCALE_BYPASS_EN
      pix_tab[0] = 24'hABCDEF;
      pix_tab[1] = 24'h123456;
      run_line(2, 7, 16'h0080, 1, -1, 0, 0, 2, 2);
      bypass = 1'b0;
`endif

      repeat (2) @(negedge sys_clk);
      chk("sb_left", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
